kcore_start_token_arbiter: RTL and testbench
============================================

Name: kcore_start_token_arbiter

Overview:
Shares one shiftreg start-token FIFO (the write_back start channel) between NUM_REQ upstream dataflow processes. Round-robin arbitration picks a requester, drives the FIFO write side (full_n/write/write_ce/din), and returns a one-cycle ack. A credit counter tracks tokens issued but not yet completed by the consumer, capping in-flight starts at MAX_INFLIGHT.

Parameters:
NUM_REQ, 4, number of requesting processes (2..8)
DATA_WIDTH, 1, start-token payload width; matches the FIFO DATA_WIDTH
MAX_INFLIGHT, 4, max issued-but-uncompleted tokens; normally the FIFO DEPTH
CNT_WIDTH, 3, inflight counter width; must hold MAX_INFLIGHT

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req_start  in  NUM_REQ  per-requester start request, held high until acked
req_data  in  NUM_REQ*DATA_WIDTH  per-requester payload, slice i = requester i, stable while req high
req_ack  out  NUM_REQ  one-hot, one-cycle pulse: token of requester i accepted by FIFO
fifo_full_n  in  1  FIFO not-full (if_full_n)
fifo_write  out  1  FIFO write strobe (if_write)
fifo_write_ce  out  1  FIFO write enable (if_write_ce), constant 1
fifo_din  out  DATA_WIDTH  FIFO data (if_din)
done_pulse  in  1  consumer finished one token; returns one credit
inflight  out  CNT_WIDTH  tokens issued, not yet completed
grant_id  out  clog2(NUM_REQ)  index of last/current grantee
idle  out  1  high when state IDLE and inflight==0
err_underflow  out  1  sticky: done_pulse seen with inflight==0

Behaviour:
- Reset (reset low, async): state IDLE; req_ack=0, fifo_write=0, fifo_din=0, inflight=0, grant_id=0, err_underflow=0. RR pointer last=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, ISSUE.
- IDLE: when any req_start is high and inflight<MAX_INFLIGHT, select the first set request at or after last+1 (mod NUM_REQ). Register grant_id and that requester's req_data into fifo_din. Go to ISSUE. Otherwise stay.
- ISSUE: fifo_write=1, driven from the registered state, not combinationally from req.
  - If fifo_full_n=1: FIFO accepts at this edge; req_ack[grant_id]=1 for exactly this cycle; inflight+1; last=grant_id; go to IDLE.
  - If fifo_full_n=0: hold fifo_write, fifo_din and grant_id; no ack. Unbounded wait.
- Throughput: one token per 2 cycles max. Latency from req rise to ack: 1 cycle (pointer idle, FIFO not full).
- Requester protocol: req_start is sampled only in IDLE. A requester must drop req_start, or present a new token, in the cycle after its ack, because IDLE re-arbitrates then. A req withdrawn during ISSUE does not cancel the grant.
- Credit: done_pulse decrements inflight. Write-accept and done_pulse in the same cycle leave inflight unchanged. done_pulse with inflight==0 is ignored (no wrap) and sets err_underflow.
- inflight==MAX_INFLIGHT: no new grant. An ISSUE already in progress completes.
- Reset mid-ISSUE: the token is dropped with no ack. The requester still holds req and is re-arbitrated after reset.

Optional Feature:
KCORE_START_ARB_STATS_EN
- Defined: adds output stall_cycles (16 bits), counting cycles in ISSUE with fifo_full_n=0. Saturates at 0xFFFF. Cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package kcore_start_pkg holds the arbiter state enum (IDLE, ISSUE), the stall counter width constant (16), and a clog2 function.
- Sub-module kcore_rr_picker is combinational. Inputs: req vector and last pointer. Outputs: winner index and valid.
- The arbiter owns the FSM, credit counter and output registers.

Test Plan:
- Single requester: req_start=0001, data=1, FIFO not full -> fifo_write high in cycle 1 with din=1, req_ack=0001 in that cycle, inflight 0->1.
- All four requesting continuously (drop/re-raise after each ack) -> grant order 0,1,2,3,0. Each ack is 2 cycles apart.
- Backpressure: fifo_full_n=0 for 5 cycles during ISSUE -> fifo_write held 5 cycles with din and grant_id stable, no ack; ack on the cycle full_n returns to 1.
- Credit cap: MAX_INFLIGHT=4, no done_pulse -> exactly 4 acks, then stays IDLE. One done_pulse -> one more grant.
- Simultaneous accept and done_pulse at inflight=2 -> inflight stays 2. done_pulse at inflight=0 -> inflight stays 0, err_underflow=1.
- Assert reset low mid-ISSUE -> fifo_write=0 and req_ack=0 immediately, inflight=0. After release, requester 0 (still requesting) is granted first.

Source files
------------

// File: rtl/kcore_start_pkg.sv
// rtl/kcore_start_pkg.sv - shared types, constants and helpers for the start-token arbiter
package kcore_start_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    localparam int STALL_CNT_W = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/kcore_rr_picker.sv
// rtl/kcore_rr_picker.sv - combinational round-robin picker, searches from last+1 upward with wrap
module kcore_rr_picker
    import kcore_start_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [IDX_W-1:0] pos;

    // The final iteration lands back on last itself, so a lone requester always wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        pos    = last;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (pos == IDX_W'(NUM_REQ - 1)) ? '0 : pos + 1'b1;
            if (!valid && req[pos]) begin
                valid  = 1'b1;
                winner = pos;
            end
        end
    end

endmodule

// File: rtl/kcore_start_token_arbiter.sv
// rtl/kcore_start_token_arbiter.sv - round-robin sharing of one start-token FIFO with credit limit
// Optional stall counter output enabled by KCORE_START_ARB_STATS_EN.
module kcore_start_token_arbiter
    import kcore_start_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 1,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_start,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    input  logic                          fifo_full_n,
    output logic                          fifo_write,
    output logic                          fifo_write_ce,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          done_pulse,
    output logic [CNT_WIDTH-1:0]          inflight,
    output logic [clog2(NUM_REQ)-1:0]     grant_id,
    output logic                          idle,
    output logic                          err_underflow
`ifdef KCORE_START_ARB_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0]        stall_cycles
`endif
);

    localparam int IDX_W = clog2(NUM_REQ);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      grant_id_q, grant_id_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  fifo_write_q, fifo_write_d;
    logic [CNT_WIDTH-1:0]  inflight_q, inflight_d;
    logic                  err_q, err_d;

    logic [IDX_W-1:0]      pick_id;
    logic                  pick_valid;
    logic [DATA_WIDTH-1:0] pick_data;
    logic                  accept;
    logic                  credit_ok;
    logic                  done_ok;

    kcore_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req_start),
        .last   (last_q),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == IDX_W'(i)) begin
                pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The FIFO takes the token on the edge that ends an ISSUE cycle with full_n high.
    assign accept    = (state_q == ST_ISSUE) && fifo_full_n;
    assign credit_ok = (inflight_q < CNT_WIDTH'(MAX_INFLIGHT));
    assign done_ok   = done_pulse && (inflight_q != '0);

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_d       = last_q;
        din_d        = din_q;
        fifo_write_d = fifo_write_q;
        inflight_d   = inflight_q + CNT_WIDTH'(accept) - CNT_WIDTH'(done_ok);
        err_d        = err_q | (done_pulse && (inflight_q == '0));

        case (state_q)
            ST_IDLE: begin
                if (pick_valid && credit_ok) begin
                    state_d      = ST_ISSUE;
                    grant_id_d   = pick_id;
                    din_d        = pick_data;
                    fifo_write_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (fifo_full_n) begin
                    state_d      = ST_IDLE;
                    fifo_write_d = 1'b0;
                    last_d       = grant_id_q;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                fifo_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_q       <= IDX_W'(NUM_REQ - 1);
            din_q        <= '0;
            fifo_write_q <= 1'b0;
            inflight_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_q       <= last_d;
            din_q        <= din_d;
            fifo_write_q <= fifo_write_d;
            inflight_q   <= inflight_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        req_ack = '0;
        if (accept) begin
            req_ack[grant_id_q] = 1'b1;
        end
    end

    assign fifo_write    = fifo_write_q;
    assign fifo_write_ce = 1'b1;
    assign fifo_din      = din_q;
    assign inflight      = inflight_q;
    assign grant_id      = grant_id_q;
    assign idle          = (state_q == ST_IDLE) && (inflight_q == '0);
    assign err_underflow = err_q;

`ifdef KCORE_START_ARB_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_ISSUE) && !fifo_full_n && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_kcore_start_token_arbiter.sv
// tb/tb_kcore_start_token_arbiter.sv - directed self-checking bench for the start-token arbiter
module tb_kcore_start_token_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_start;
    logic [3:0] req_data;
    logic [3:0] req_ack;
    logic       fifo_full_n;
    logic       fifo_write;
    logic       fifo_write_ce;
    logic       fifo_din;
    logic       done_pulse;
    logic [2:0] inflight;
    logic [1:0] grant_id;
    logic       idle;
    logic       err_underflow;
`ifdef KCORE_START_ARB_STATS_EN
    logic [15:0] stall_cycles;
`endif

    int nvec;
    int nerr;

    kcore_start_token_arbiter #(
        .NUM_REQ      (4),
        .DATA_WIDTH   (1),
        .MAX_INFLIGHT (4),
        .CNT_WIDTH    (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_start     (req_start),
        .req_data      (req_data),
        .req_ack       (req_ack),
        .fifo_full_n   (fifo_full_n),
        .fifo_write    (fifo_write),
        .fifo_write_ce (fifo_write_ce),
        .fifo_din      (fifo_din),
        .done_pulse    (done_pulse),
        .inflight      (inflight),
        .grant_id      (grant_id),
        .idle          (idle),
        .err_underflow (err_underflow)
`ifdef KCORE_START_ARB_STATS_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_start = '0; req_data = '0; fifo_full_n = 1'b1; done_pulse = 1'b0;
        step(); step();
        nvec++; if (fifo_write !== 1'b0) begin nerr++; $display("FAIL reset_write got=%b exp=0", fifo_write); end
        nvec++; if (req_ack !== 4'b0000) begin nerr++; $display("FAIL reset_ack got=%b exp=0000", req_ack); end
        nvec++; if (inflight !== 3'd0) begin nerr++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        nvec++; if (grant_id !== 2'd0) begin nerr++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        nvec++; if (fifo_din !== 1'b0) begin nerr++; $display("FAIL reset_din got=%b exp=0", fifo_din); end
        nvec++; if (err_underflow !== 1'b0) begin nerr++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
        nvec++; if (idle !== 1'b1) begin nerr++; $display("FAIL reset_idle got=%b exp=1", idle); end
        nvec++; if (fifo_write_ce !== 1'b1) begin nerr++; $display("FAIL reset_ce got=%b exp=1", fifo_write_ce); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        req_start = 4'b0001; req_data = 4'b0001;
        nvec++; if (fifo_write !== 1'b0) begin nerr++; $display("FAIL single_c0_write got=%b exp=0", fifo_write); end
        step();
        nvec++; if (fifo_write !== 1'b1) begin nerr++; $display("FAIL single_write got=%b exp=1", fifo_write); end
        nvec++; if (fifo_din !== 1'b1) begin nerr++; $display("FAIL single_din got=%b exp=1", fifo_din); end
        nvec++; if (req_ack !== 4'b0001) begin nerr++; $display("FAIL single_ack got=%b exp=0001", req_ack); end
        nvec++; if (inflight !== 3'd0) begin nerr++; $display("FAIL single_inflight_pre got=%0d exp=0", inflight); end
        req_start = 4'b0000;
        step();
        nvec++; if (inflight !== 3'd1) begin nerr++; $display("FAIL single_inflight_post got=%0d exp=1", inflight); end
        nvec++; if (fifo_write !== 1'b0 || req_ack !== 4'b0000) begin nerr++; $display("FAIL single_after write=%b ack=%b exp=0/0000", fifo_write, req_ack); end
        nvec++; if (idle !== 1'b0) begin nerr++; $display("FAIL single_idle got=%b exp=0", idle); end
        done_pulse = 1'b1;
        step();
        done_pulse = 1'b0;
        nvec++; if (inflight !== 3'd0 || idle !== 1'b1) begin nerr++; $display("FAIL single_done inflight=%0d idle=%b exp=0/1", inflight, idle); end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        logic [3:0] data_bits;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        data_bits = 4'b1010;
        reset = 1'b0; step(); reset = 1'b1;
        req_data = data_bits; req_start = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            done_pulse = 1'b0;
            nvec++; if (req_ack !== (4'b0001 << order[k])) begin nerr++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, req_ack, 4'b0001 << order[k]); end
            nvec++; if (grant_id !== order[k] || fifo_din !== data_bits[order[k]]) begin nerr++; $display("FAIL rr_grant[%0d] id=%0d din=%b exp=%0d/%b", k, grant_id, fifo_din, order[k], data_bits[order[k]]); end
            if (k == 4) req_start = 4'b0000; else req_start[order[k]] = 1'b0;
            step();
            nvec++; if (req_ack !== 4'b0000 || inflight !== 3'd1) begin nerr++; $display("FAIL rr_gap[%0d] ack=%b inflight=%0d exp=0000/1", k, req_ack, inflight); end
            if (k < 4) req_start[order[k]] = 1'b1;
            done_pulse = 1'b1;
        end
        step();
        done_pulse = 1'b0;
        nvec++; if (inflight !== 3'd0 || idle !== 1'b1) begin nerr++; $display("FAIL rr_end inflight=%0d idle=%b exp=0/1", inflight, idle); end
    endtask

    task automatic test_backpressure();
        fifo_full_n = 1'b0; req_data = 4'b0010; req_start = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            nvec++; if (fifo_write !== 1'b1 || fifo_din !== 1'b1 || grant_id !== 2'd1) begin nerr++; $display("FAIL bp_hold[%0d] write=%b din=%b id=%0d exp=1/1/1", i, fifo_write, fifo_din, grant_id); end
            nvec++; if (req_ack !== 4'b0000) begin nerr++; $display("FAIL bp_noack[%0d] got=%b exp=0000", i, req_ack); end
        end
        step();
        fifo_full_n = 1'b1;
        #1;
        nvec++; if (req_ack !== 4'b0010 || fifo_write !== 1'b1) begin nerr++; $display("FAIL bp_ack ack=%b write=%b exp=0010/1", req_ack, fifo_write); end
        req_start = 4'b0000;
        step();
        nvec++; if (inflight !== 3'd1 || fifo_write !== 1'b0) begin nerr++; $display("FAIL bp_post inflight=%0d write=%b exp=1/0", inflight, fifo_write); end
        done_pulse = 1'b1;
        step();
        done_pulse = 1'b0;
    endtask

    task automatic test_credit_cap();
        logic [3:0] exp_ack [5];
        int acks;
        exp_ack = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        acks = 0;
        req_start = 4'b1111; req_data = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            step();
            if (req_ack !== 4'b0000) begin
                nvec++; if (acks >= 4 || req_ack !== exp_ack[acks]) begin nerr++; $display("FAIL cap_order[%0d] got=%b", acks, req_ack); end
                acks++;
            end
        end
        nvec++; if (acks !== 4) begin nerr++; $display("FAIL cap_count got=%0d exp=4", acks); end
        nvec++; if (inflight !== 3'd4 || fifo_write !== 1'b0) begin nerr++; $display("FAIL cap_stall inflight=%0d write=%b exp=4/0", inflight, fifo_write); end
        done_pulse = 1'b1;
        step();
        done_pulse = 1'b0;
        nvec++; if (inflight !== 3'd3) begin nerr++; $display("FAIL cap_credit got=%0d exp=3", inflight); end
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (req_ack !== 4'b0000) begin
                nvec++; if (acks >= 1 || req_ack !== exp_ack[4]) begin nerr++; $display("FAIL cap_extra[%0d] got=%b exp=%b", acks, req_ack, exp_ack[4]); end
                acks++;
            end
        end
        nvec++; if (acks !== 1 || inflight !== 3'd4) begin nerr++; $display("FAIL cap_extra_count acks=%0d inflight=%0d exp=1/4", acks, inflight); end
        req_start = 4'b0000; done_pulse = 1'b1;
        step(); step(); step(); step();
        done_pulse = 1'b0;
        nvec++; if (inflight !== 3'd0 || err_underflow !== 1'b0) begin nerr++; $display("FAIL cap_drain inflight=%0d err=%b exp=0/0", inflight, err_underflow); end
    endtask

    task automatic test_credit_edges();
        req_start = 4'b0001; req_data = 4'b0000;
        step(); step(); step(); step(); step();
        nvec++; if (inflight !== 3'd2 || req_ack !== 4'b0001) begin nerr++; $display("FAIL edge_pre inflight=%0d ack=%b exp=2/0001", inflight, req_ack); end
        done_pulse = 1'b1; req_start = 4'b0000;
        step();
        nvec++; if (inflight !== 3'd2) begin nerr++; $display("FAIL edge_same_cycle got=%0d exp=2", inflight); end
        step(); step();
        nvec++; if (inflight !== 3'd0 || err_underflow !== 1'b0) begin nerr++; $display("FAIL edge_drain inflight=%0d err=%b exp=0/0", inflight, err_underflow); end
        step();
        done_pulse = 1'b0;
        nvec++; if (inflight !== 3'd0 || err_underflow !== 1'b1) begin nerr++; $display("FAIL edge_underflow inflight=%0d err=%b exp=0/1", inflight, err_underflow); end
        step();
        nvec++; if (err_underflow !== 1'b1) begin nerr++; $display("FAIL edge_sticky got=%b exp=1", err_underflow); end
    endtask

    task automatic test_reset_mid_issue();
        fifo_full_n = 1'b0; req_data = 4'b0001; req_start = 4'b0011;
        step();
        nvec++; if (fifo_write !== 1'b1 || grant_id !== 2'd1) begin nerr++; $display("FAIL mid_issue write=%b id=%0d exp=1/1", fifo_write, grant_id); end
        reset = 1'b0; fifo_full_n = 1'b1;
        #1;
        nvec++; if (fifo_write !== 1'b0 || req_ack !== 4'b0000) begin nerr++; $display("FAIL mid_async write=%b ack=%b exp=0/0000", fifo_write, req_ack); end
        nvec++; if (inflight !== 3'd0 || err_underflow !== 1'b0 || grant_id !== 2'd0) begin nerr++; $display("FAIL mid_state inflight=%0d err=%b id=%0d exp=0/0/0", inflight, err_underflow, grant_id); end
        step();
        reset = 1'b1;
        step();
        nvec++; if (req_ack !== 4'b0001 || grant_id !== 2'd0 || fifo_din !== 1'b1) begin nerr++; $display("FAIL mid_regrant ack=%b id=%0d din=%b exp=0001/0/1", req_ack, grant_id, fifo_din); end
        req_start = 4'b0000;
        step();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_credit_cap();
        test_credit_edges();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
